// File: rtl/agc_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// agc_pipe_ctrl : scoreboard RAW stall, branch flush and halt sequencing.
// Optional build macro: AGC_PIPE_BYPASS_EN (write-through regfile).  Rev 1.0
// ============================================================================

module agc_pipe_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int WB_DIST  = 2
) (
  input  logic                clock,
  input  logic                rst_l,
  input  logic                d_valid,
  input  logic [SEL_W-1:0]    d_rs1_sel,
  input  logic                d_rs1_use,
  input  logic [SEL_W-1:0]    d_rs2_sel,
  input  logic                d_rs2_use,
  input  logic [SEL_W-1:0]    d_wr1_sel,
  input  logic                d_wr1_en,
  input  logic [SEL_W-1:0]    d_wr2_sel,
  input  logic                d_wr2_en,
  input  logic                d_halt,
  input  logic                e_branch,
  input  logic                w_halt,
  output logic                stall_D,
  output logic                flush_E,
  output logic                halt,
  output logic [NUM_REGS-1:0] busy_map
);

  localparam int         SEL_N     = 1 << SEL_W;
  localparam logic [3:0] C_WB_DIST = 4'(WB_DIST);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e             state_q;
  logic               halt_q;
  logic [SEL_N-1:0]   hazard_busy;
  logic               hazard;
  logic               issue;

  // Untracked select codes read as never busy, so out-of-range selects never stall.
  for (genvar gi = 0; gi < SEL_N; gi++) begin : g_reg
    if (gi < NUM_REGS) begin : g_tracked
      logic [3:0] cnt_q;
      logic [3:0] cnt_d;
      logic       ld;

      assign ld = issue & ((d_wr1_en & (d_wr1_sel == SEL_W'(gi))) |
                           (d_wr2_en & (d_wr2_sel == SEL_W'(gi))));

      always_comb begin
        cnt_d = cnt_q;
        if (ld)
          cnt_d = C_WB_DIST;
        else if (cnt_q != 4'd0)
          cnt_d = cnt_q - 4'd1;
      end

      always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l)
          cnt_q <= 4'd0;
        else
          cnt_q <= cnt_d;
      end

      assign busy_map[gi] = (cnt_q != 4'd0);
`ifdef AGC_PIPE_BYPASS_EN
      assign hazard_busy[gi] = (cnt_q > 4'd1);
`else
      assign hazard_busy[gi] = busy_map[gi];
`endif
    end else begin : g_untracked
      assign hazard_busy[gi] = 1'b0;
    end
  end

  assign hazard  = d_valid & ((d_rs1_use & hazard_busy[d_rs1_sel]) |
                              (d_rs2_use & hazard_busy[d_rs2_sel]));
  assign flush_E = e_branch & (state_q == RUN);
  assign stall_D = (state_q != RUN) | (hazard & ~flush_E);
  assign issue   = d_valid & ~stall_D & ~flush_E & (state_q == RUN);
  assign halt    = halt_q;

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (issue & d_halt)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (w_halt) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end
        end
        HALTED: begin
          halt_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_agc_pipe_ctrl.sv
`default_nettype none
// tb_agc_pipe_ctrl : directed self-checking bench for agc_pipe_ctrl (default parameters).

module tb_agc_pipe_ctrl;

  logic       clock = 1'b0;
  logic       rst_l;
  logic       d_valid;
  logic [2:0] d_rs1_sel;
  logic       d_rs1_use;
  logic [2:0] d_rs2_sel;
  logic       d_rs2_use;
  logic [2:0] d_wr1_sel;
  logic       d_wr1_en;
  logic [2:0] d_wr2_sel;
  logic       d_wr2_en;
  logic       d_halt;
  logic       e_branch;
  logic       w_halt;
  logic       stall_D;
  logic       flush_E;
  logic       halt;
  logic [7:0] busy_map;

  int errors = 0;
  int checks = 0;

  agc_pipe_ctrl #(.NUM_REGS(8), .SEL_W(3), .WB_DIST(2)) dut (
    .clock     (clock),
    .rst_l     (rst_l),
    .d_valid   (d_valid),
    .d_rs1_sel (d_rs1_sel),
    .d_rs1_use (d_rs1_use),
    .d_rs2_sel (d_rs2_sel),
    .d_rs2_use (d_rs2_use),
    .d_wr1_sel (d_wr1_sel),
    .d_wr1_en  (d_wr1_en),
    .d_wr2_sel (d_wr2_sel),
    .d_wr2_en  (d_wr2_en),
    .d_halt    (d_halt),
    .e_branch  (e_branch),
    .w_halt    (w_halt),
    .stall_D   (stall_D),
    .flush_E   (flush_E),
    .halt      (halt),
    .busy_map  (busy_map)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    d_valid   = 1'b0;
    d_rs1_sel = 3'd0;
    d_rs1_use = 1'b0;
    d_rs2_sel = 3'd0;
    d_rs2_use = 1'b0;
    d_wr1_sel = 3'd0;
    d_wr1_en  = 1'b0;
    d_wr2_sel = 3'd0;
    d_wr2_en  = 1'b0;
    d_halt    = 1'b0;
    e_branch  = 1'b0;
    w_halt    = 1'b0;
  endtask

  initial begin
    // Reset asserted between edges
    idle();
    rst_l = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_D), 32'd0);
    chk("rst_flush", 32'(flush_E), 32'd0);
    chk("rst_halt",  32'(halt),    32'd0);
    chk("rst_busy",  32'(busy_map), 32'h00);
    tick();
    tick();
    #2;
    rst_l = 1'b1;

    // Independent instruction issues straight after reset
    tick();
    d_valid = 1'b1; d_rs1_sel = 3'd0; d_rs1_use = 1'b1; d_wr1_sel = 3'd1; d_wr1_en = 1'b1;
    #1;
    chk("t1_stall", 32'(stall_D), 32'd0);
    tick();
    idle();
    #1;
    chk("t1_busy", 32'(busy_map), 32'h02);
    tick();
    tick();
    chk("t1_busy_clr", 32'(busy_map), 32'h00);

    // Back-to-back RAW on r3
    d_valid = 1'b1; d_wr1_sel = 3'd3; d_wr1_en = 1'b1;
    #1;
    chk("t2_i1_stall", 32'(stall_D), 32'd0);
    tick();
    idle();
    d_valid = 1'b1; d_rs1_sel = 3'd3; d_rs1_use = 1'b1; d_wr1_sel = 3'd4; d_wr1_en = 1'b1;
    #1;
    chk("t2_stall_c1", 32'(stall_D), 32'd1);
    chk("t2_busy_c1",  32'(busy_map), 32'h08);
    tick();
    #1;
`ifdef AGC_PIPE_BYPASS_EN
    chk("t2_stall_c2", 32'(stall_D), 32'd0);
    chk("t2_busy_c2",  32'(busy_map), 32'h08);
`else
    chk("t2_stall_c2", 32'(stall_D), 32'd1);
    chk("t2_busy_c2",  32'(busy_map), 32'h08);
    tick();
    #1;
    chk("t2_stall_c3", 32'(stall_D), 32'd0);
    chk("t2_busy_c3",  32'(busy_map), 32'h00);
`endif
    tick();
    idle();
    #1;
    chk("t2_i2_busy", 32'(busy_map), 32'h10);
    tick();
    tick();

    // Branch flush beats the hazard; squashed writer leaves no trace
    d_valid = 1'b1; d_wr1_sel = 3'd3; d_wr1_en = 1'b1;
    tick();
    idle();
    d_valid = 1'b1; d_rs1_sel = 3'd3; d_rs1_use = 1'b1; d_wr1_sel = 3'd5; d_wr1_en = 1'b1;
    e_branch = 1'b1;
    #1;
    chk("t3_flush", 32'(flush_E), 32'd1);
    chk("t3_stall", 32'(stall_D), 32'd0);
    tick();
    idle();
    #1;
    chk("t3_busy", 32'(busy_map), 32'h08);
    tick();
    chk("t3_busy_clr", 32'(busy_map), 32'h00);

    // Same-register dual write, then reload by a second writer
    d_valid = 1'b1; d_wr1_sel = 3'd6; d_wr1_en = 1'b1; d_wr2_sel = 3'd6; d_wr2_en = 1'b1;
    tick();
    idle();
    d_valid = 1'b1; d_wr1_sel = 3'd6; d_wr1_en = 1'b1;
    #1;
    chk("t4_busy_c1", 32'(busy_map), 32'h40);
    tick();
    idle();
    #1;
    chk("t4_busy_c2", 32'(busy_map), 32'h40);
    tick();
    chk("t4_busy_c3", 32'(busy_map), 32'h40);
    tick();
    chk("t4_busy_c4", 32'(busy_map), 32'h00);
    d_valid = 1'b1; d_wr1_sel = 3'd2; d_wr1_en = 1'b1; d_wr2_sel = 3'd6; d_wr2_en = 1'b1;
    tick();
    idle();
    #1;
    chk("t4_dual", 32'(busy_map), 32'h44);
    tick();
    tick();

    // Halt sequencing
    d_valid = 1'b1; d_halt = 1'b1;
    #1;
    chk("t5_halt_issue", 32'(stall_D), 32'd0);
    tick();
    idle();
    d_valid = 1'b1; d_wr1_sel = 3'd7; d_wr1_en = 1'b1;
    #1;
    chk("t5_drain_stall", 32'(stall_D), 32'd1);
    chk("t5_drain_halt",  32'(halt),    32'd0);
    tick();
    idle();
    w_halt = 1'b1;
    #1;
    chk("t5_whalt_halt", 32'(halt), 32'd0);
    chk("t5_drain_noiss", 32'(busy_map), 32'h00);
    tick();
    w_halt = 1'b0;
    e_branch = 1'b1;
    #1;
    chk("t5_halted",       32'(halt),    32'd1);
    chk("t5_halted_stall", 32'(stall_D), 32'd1);
    chk("t5_halted_flush", 32'(flush_E), 32'd0);
    tick();
    chk("t5_halt_hold", 32'(halt), 32'd1);

    // Reset out of HALTED, then reset mid-DRAIN with r1 busy
    #1;
    rst_l = 1'b0;
    #1;
    chk("t6_rst_halt", 32'(halt), 32'd0);
    #1;
    rst_l = 1'b1;
    idle();
    tick();
    d_valid = 1'b1; d_halt = 1'b1; d_wr1_sel = 3'd1; d_wr1_en = 1'b1;
    #1;
    chk("t6_issue", 32'(stall_D), 32'd0);
    tick();
    idle();
    #1;
    chk("t6_drain_stall", 32'(stall_D), 32'd1);
    chk("t6_drain_busy",  32'(busy_map), 32'h02);
    #1;
    rst_l = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(busy_map), 32'h00);
    chk("t6_rst_stall", 32'(stall_D),  32'd0);
    chk("t6_rst_halt",  32'(halt),     32'd0);
    #1;
    rst_l = 1'b1;
    d_valid = 1'b1; d_rs1_sel = 3'd1; d_rs1_use = 1'b1; d_wr1_sel = 3'd0; d_wr1_en = 1'b1;
    #1;
    chk("t6_post_stall", 32'(stall_D), 32'd0);
    tick();
    idle();
    #1;
    chk("t6_post_busy", 32'(busy_map), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
